// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM ballot unit.
package evm_pkg;

    // Ballot controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ACCEPT  = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_SCAN    = 3'd4,
        ST_RESULT  = 3'd5
    } evm_state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evm_button_debounce.sv
// One candidate button: 2-FF synchroniser followed by a debounce counter.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it; rise pulses for one cycle on 0->1.
module evm_button_debounce
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = idx_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    // NOTE: registers are written with <= so every flop samples the pre-edge
    // value; blocking writes here would collapse the two sync stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Count consecutive disagreeing samples; flip the level when the run is long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    level <= sync[1];
                    rise  <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/evm_ballot_unit.sv
// EVM voting core: debounced candidate buttons, one vote per armed ballot,
// saturating per-candidate tallies and a sequential winner scan.
module evm_ballot_unit
    import evm_pkg::*;
#(
    parameter int  NUM_CAND        = 4,
    parameter int  CNT_W           = 8,
    parameter int  DEBOUNCE_CYCLES = 16,
    parameter int  LOCKOUT_CYCLES  = 8,
    localparam int IDX_W           = idx_width(NUM_CAND),
    localparam int TOT_W           = CNT_W + IDX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] buttons,
    input  logic                ballot_arm,
    output logic                ballot_ready,
    output logic                vote_ack,
    output logic                vote_reject,
    output logic [IDX_W-1:0]    vote_idx,
    output logic [TOT_W-1:0]    total_votes,
    output logic                overflow,
    output logic                result_valid,
    output logic [IDX_W-1:0]    winner_idx,
    output logic [NUM_CAND-1:0] winner_onehot,
    output logic [CNT_W-1:0]    winning_votes,
    output logic                tie,
    output logic                no_votes
);

    localparam int LOCK_W = idx_width(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  SCAN_LAST = IDX_W'(NUM_CAND - 1);
    localparam logic [CNT_W-1:0]  TALLY_MAX = '1;

    evm_state_t          state, next_state;

    logic [NUM_CAND-1:0] level;
    logic [NUM_CAND-1:0] rise;
    logic                press_any;
    logic                press_one;
    logic                press_multi;
    logic [IDX_W-1:0]    press_idx;

    logic [LOCK_W-1:0]   lock_cnt;
    logic [CNT_W-1:0]    tally [NUM_CAND];

    logic                scan_start;
    logic [IDX_W-1:0]    scan_idx;
    logic [IDX_W-1:0]    best_idx;
    logic [CNT_W-1:0]    best_val;
    logic                best_tie;
    logic [CNT_W-1:0]    cand_val;
    logic [IDX_W-1:0]    step_idx;
    logic [CNT_W-1:0]    step_val;
    logic                step_tie;

    // One debouncer per candidate button.
    for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
        evm_button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (buttons[g]),
            .level(level[g]),
            .rise (rise[g])
        );
    end

    // Classify this cycle's press events: none, exactly one (with its index), or several.
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        press_any   = 1'b0;
        press_multi = 1'b0;
        press_idx   = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (rise[i]) begin
                if (press_any) begin
                    press_multi = 1'b1;
                end else begin
                    press_any = 1'b1;
                    press_idx = IDX_W'(i);
                end
            end
        end
        press_one = press_any && !press_multi;
    end

    // Ballot controller next state; result mode always takes priority over voting.
    always_comb begin
        next_state  = state;
        vote_reject = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mode)            next_state = ST_SCAN;
                else if (ballot_arm) next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (mode) begin
                    next_state = ST_SCAN;
                end else if (press_multi) begin
                    vote_reject = 1'b1;
                    next_state  = ST_LOCKOUT;
                end else if (press_one) begin
                    next_state = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                next_state = mode ? ST_SCAN : ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (mode)                                  next_state = ST_SCAN;
                else if (level == '0 && lock_cnt == LOCK_LAST) next_state = ST_IDLE;
            end
            ST_SCAN: begin
                if (scan_idx == SCAN_LAST) next_state = ST_RESULT;
            end
            ST_RESULT: begin
                if (!mode) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Count idle cycles after every button is released; any press restarts the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (state == ST_LOCKOUT && level == '0) begin
            lock_cnt <= lock_cnt + 1'b1;
        end else begin
            lock_cnt <= '0;
        end
    end

    // Remember which candidate the accepted ballot selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_idx <= '0;
        end else if (state == ST_ARMED && next_state == ST_ACCEPT) begin
            vote_idx <= press_idx;
        end
    end

    // Commit an accepted vote: saturating tally, running total, sticky overflow.
    // NOTE: the tally array is a small register file whose contents must read
    // zero after reset, so it is cleared in the reset branch rather than left to a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            total_votes <= '0;
            overflow    <= 1'b0;
        end else if (state == ST_ACCEPT) begin
            total_votes <= total_votes + 1'b1;
            if (tally[vote_idx] == TALLY_MAX) begin
                overflow <= 1'b1;
            end else begin
                tally[vote_idx] <= tally[vote_idx] + 1'b1;
            end
        end
    end

    // One scan step: a strictly larger tally takes the lead; an equal nonzero one marks a tie.
    always_comb begin
        cand_val = tally[scan_idx];
        step_idx = best_idx;
        step_val = best_val;
        step_tie = best_tie;
        if (cand_val > best_val) begin
            step_idx = scan_idx;
            step_val = cand_val;
            step_tie = 1'b0;
        end else if (cand_val == best_val && cand_val != '0) begin
            step_tie = 1'b1;
        end
    end

    assign scan_start = (next_state == ST_SCAN) && (state != ST_SCAN);

    // Walk the tallies one candidate per cycle, keeping the running best.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_val <= '0;
            best_tie <= 1'b0;
        end else if (scan_start) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_val <= '0;
            best_tie <= 1'b0;
        end else if (state == ST_SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            best_idx <= step_idx;
            best_val <= step_val;
            best_tie <= step_tie;
        end
    end

    // Latch the final comparison as the reported result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_idx    <= '0;
            winning_votes <= '0;
            tie           <= 1'b0;
            no_votes      <= 1'b0;
        end else if (state == ST_SCAN && scan_idx == SCAN_LAST) begin
            winner_idx    <= step_idx;
            winning_votes <= step_val;
            tie           <= step_tie;
            no_votes      <= (step_val == '0);
        end
    end

    // Status flags and winner LED drive decoded from the current state.
    always_comb begin
        ballot_ready  = (state == ST_ARMED);
        vote_ack      = (state == ST_ACCEPT);
        result_valid  = (state == ST_RESULT);
        winner_onehot = '0;
        if (result_valid && !no_votes) winner_onehot[winner_idx] = 1'b1;
    end

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Self-checking bench for evm_ballot_unit: table-driven ballots, a scoreboard
// of expected ack/reject events, and hand-written multi-cycle corner cases.
module tb_evm_ballot_unit;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int DB = 4;
    localparam int LK = 8;
    localparam int IW = 2;
    localparam int TW = CW + IW;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [NC-1:0] buttons;
    logic          ballot_arm;
    logic          ballot_ready;
    logic          vote_ack;
    logic          vote_reject;
    logic [IW-1:0] vote_idx;
    logic [TW-1:0] total_votes;
    logic          overflow;
    logic          result_valid;
    logic [IW-1:0] winner_idx;
    logic [NC-1:0] winner_onehot;
    logic [CW-1:0] winning_votes;
    logic          tie;
    logic          no_votes;

    evm_ballot_unit #(
        .NUM_CAND       (NC),
        .CNT_W          (CW),
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .buttons      (buttons),
        .ballot_arm   (ballot_arm),
        .ballot_ready (ballot_ready),
        .vote_ack     (vote_ack),
        .vote_reject  (vote_reject),
        .vote_idx     (vote_idx),
        .total_votes  (total_votes),
        .overflow     (overflow),
        .result_valid (result_valid),
        .winner_idx   (winner_idx),
        .winner_onehot(winner_onehot),
        .winning_votes(winning_votes),
        .tie          (tie),
        .no_votes     (no_votes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    typedef struct {
        logic          is_reject;
        logic [IW-1:0] idx;
    } sb_item_t;

    typedef struct {
        logic [NC-1:0] pattern;
        logic          exp_ack;
        logic          exp_rej;
        logic [IW-1:0] exp_idx;
    } vec_t;

    sb_item_t sb_q[$];

    int ack_count        = 0;
    int rej_count        = 0;
    int overlap_count    = 0;
    int long_pulse_count = 0;

    // Event monitor: pops the scoreboard whenever the DUT acks or rejects.
    initial begin
        logic     prev_ack;
        logic     prev_rej;
        sb_item_t e;
        prev_ack = 1'b0;
        prev_rej = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ack = 1'b0;
                prev_rej = 1'b0;
            end else begin
                if (vote_ack && vote_reject) overlap_count++;
                if ((vote_ack && prev_ack) || (vote_reject && prev_rej)) long_pulse_count++;
                if (vote_ack || vote_reject) begin
                    check("sb_pending", 64'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sb_kind_reject", vote_reject, e.is_reject);
                        if (!e.is_reject) check("sb_vote_idx", vote_idx, e.idx);
                    end
                    if (vote_ack)    ack_count++;
                    if (vote_reject) rej_count++;
                end
                prev_ack = vote_ack;
                prev_rej = vote_reject;
            end
        end
    end

    // Hard stop in case something hangs.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},    ballot_ready,  0);
        check({tag, "_ack"},      vote_ack,      0);
        check({tag, "_reject"},   vote_reject,   0);
        check({tag, "_vote_idx"}, vote_idx,      0);
        check({tag, "_total"},    total_votes,   0);
        check({tag, "_overflow"}, overflow,      0);
        check({tag, "_rvalid"},   result_valid,  0);
        check({tag, "_win_idx"},  winner_idx,    0);
        check({tag, "_onehot"},   winner_onehot, 0);
        check({tag, "_win_vot"},  winning_votes, 0);
        check({tag, "_tie"},      tie,           0);
        check({tag, "_no_vot"},   no_votes,      0);
    endtask

    task automatic push_expect(input logic is_rej, input logic [IW-1:0] idx);
        sb_item_t e;
        e.is_reject = is_rej;
        e.idx       = idx;
        sb_q.push_back(e);
    endtask

    // Arm one ballot, hold the pattern, release and wait out debounce + lockout.
    task automatic cast_ballot(input logic [NC-1:0] pattern, input int hold);
        @(posedge clk); #1;
        ballot_arm = 1'b1;
        @(posedge clk); #1;
        ballot_arm = 1'b0;
        buttons    = pattern;
        repeat (hold) @(posedge clk);
        #1;
        buttons = '0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Enter result mode and check the scan outcome and latency.
    task automatic do_scan(input string tag, input logic [IW-1:0] exp_win, input logic [CW-1:0] exp_votes,
                           input logic exp_tie, input logic exp_none);
        int            first;
        logic [NC-1:0] exp_oh;
        exp_oh = exp_none ? '0 : (NC'(1) << exp_win);
        first  = 0;
        @(posedge clk); #1;
        mode = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (result_valid && first == 0) first = n;
        end
        check({tag, "_scan_latency"}, first, NC + 1);
        check({tag, "_rvalid_held"},  result_valid,  1);
        check({tag, "_winner_idx"},   winner_idx,    exp_win);
        check({tag, "_winning"},      winning_votes, exp_votes);
        check({tag, "_tie"},          tie,           exp_tie);
        check({tag, "_no_votes"},     no_votes,      exp_none);
        check({tag, "_onehot"},       winner_onehot, exp_oh);
        mode = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rvalid_clr"}, result_valid,  0);
        check({tag, "_onehot_clr"}, winner_onehot, 0);
    endtask

    vec_t vecs[13];

    initial begin
        int   first;
        int   acks0;
        int   rejs0;
        logic bounce [10];

        // Ballot table: tallies end up as 3,5,5,0 once the earlier hand tests add two votes for 2.
        vecs[0]  = '{4'b0001, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{4'b0010, 1'b1, 1'b0, 2'd1};
        vecs[2]  = '{4'b0100, 1'b1, 1'b0, 2'd2};
        vecs[3]  = '{4'b1100, 1'b0, 1'b1, 2'd0};
        vecs[4]  = '{4'b0001, 1'b1, 1'b0, 2'd0};
        vecs[5]  = '{4'b0010, 1'b1, 1'b0, 2'd1};
        vecs[6]  = '{4'b0010, 1'b1, 1'b0, 2'd1};
        vecs[7]  = '{4'b0100, 1'b1, 1'b0, 2'd2};
        vecs[8]  = '{4'b0011, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{4'b0010, 1'b1, 1'b0, 2'd1};
        vecs[10] = '{4'b0001, 1'b1, 1'b0, 2'd0};
        vecs[11] = '{4'b0100, 1'b1, 1'b0, 2'd2};
        vecs[12] = '{4'b0010, 1'b1, 1'b0, 2'd1};

        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n      = 1'b0;
        mode       = 1'b0;
        buttons    = '0;
        ballot_arm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("after_reset");

        // Result mode with nothing counted.
        do_scan("empty", 2'd0, 8'd0, 1'b0, 1'b1);

        // Press-to-ack latency: the cycle the press lands in is cycle 1.
        ballot_arm = 1'b1;
        @(posedge clk); #1;
        ballot_arm = 1'b0;
        check("armed_ready", ballot_ready, 1);
        buttons = 4'b0100;
        push_expect(1'b0, 2'd2);
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (vote_ack && first == 0) first = n + 1;
            if (n == 10) buttons = '0;
        end
        repeat (10) @(posedge clk);
        #1;
        check("ack_latency_cycle", first, 2 + DB + 1 + 1);
        check("latency_vote_idx",  vote_idx, 2);
        check("latency_total",     total_votes, 1);
        check("ready_after_vote",  ballot_ready, 0);

        // Bouncing press: glitches shorter than the debounce window, then steady.
        acks0 = ack_count;
        @(posedge clk); #1;
        ballot_arm = 1'b1;
        @(posedge clk); #1;
        ballot_arm = 1'b0;
        push_expect(1'b0, 2'd2);
        for (int k = 0; k < 10; k++) begin
            buttons[2] = bounce[k];
            @(posedge clk); #1;
        end
        buttons[2] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        buttons = '0;
        repeat (20) @(posedge clk);
        #1;
        check("bounce_one_ack", ack_count - acks0, 1);

        // Second press without re-arming is ignored.
        acks0   = ack_count;
        buttons = 4'b0100;
        repeat (12) @(posedge clk);
        #1;
        check("no_arm_ready", ballot_ready, 0);
        buttons = '0;
        repeat (20) @(posedge clk);
        #1;
        check("no_arm_no_ack", ack_count - acks0, 0);
        check("no_arm_total",  total_votes, 2);

        // Simultaneous presses void the ballot.
        acks0 = ack_count;
        rejs0 = rej_count;
        push_expect(1'b1, 2'd0);
        cast_ballot(4'b1001, 12);
        check("multi_reject", rej_count - rejs0, 1);
        check("multi_no_ack", ack_count - acks0, 0);
        check("multi_total",  total_votes, 2);

        // Table-driven ballots.
        for (int v = 0; v < 13; v++) begin
            acks0 = ack_count;
            rejs0 = rej_count;
            push_expect(vecs[v].exp_rej, vecs[v].exp_idx);
            cast_ballot(vecs[v].pattern, 12);
            check($sformatf("vec%0d_ack", v), ack_count - acks0, vecs[v].exp_ack);
            check($sformatf("vec%0d_rej", v), rej_count - rejs0, vecs[v].exp_rej);
        end
        check("table_total",    total_votes, 13);
        check("table_overflow", overflow,    0);

        // Tallies 3,5,5,0: lowest index wins the tie.
        do_scan("tie", 2'd1, 8'd5, 1'b1, 1'b0);

        // Reset while a ballot is armed.
        @(posedge clk); #1;
        ballot_arm = 1'b1;
        @(posedge clk); #1;
        ballot_arm = 1'b0;
        check("pre_reset_ready", ballot_ready, 1);
        rst_n = 1'b0;
        #2;
        check_all_zero("mid_armed_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturation: 257 votes for candidate 1.
        acks0 = ack_count;
        for (int v = 0; v < 257; v++) begin
            push_expect(1'b0, 2'd1);
            cast_ballot(4'b0010, 12);
        end
        check("sat_acks",     ack_count - acks0, 257);
        check("sat_total",    total_votes, 257);
        check("sat_overflow", overflow,    1);
        do_scan("sat", 2'd1, 8'd255, 1'b0, 1'b0);

        check("ack_reject_overlap", overlap_count,    0);
        check("pulse_width",        long_pulse_count, 0);
        check("sb_drained",         sb_q.size(),      0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
